// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM states, access-width codes and the funct3 unsigned-load bit.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam int F3_UNS = 2;

    // funct3[1:0] = 11 has no RV32I meaning; treat it as a word access
    function automatic logic [1:0] norm_width(input logic [1:0] w);
        return (w == 2'b11) ? MEM_W : w;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for loads/stores: extension, byte enables and merge.
// DATA_MEM_MISALIGN_CHECK_EN flags unaligned half/word accesses.
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_ram_word,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word,
    output logic [3:0]  o_byte_en,
    output logic        o_misalign
);

    logic [1:0]  w_width;
    logic [1:0]  w_off;
    logic [31:0] w_shift;
    logic [31:0] w_rep;
    logic        w_sx;

    assign w_width = norm_width(i_funct3[1:0]);
    assign w_shift = i_ram_word >> {w_off, 3'b000};
    assign w_sx    = ~i_funct3[F3_UNS];

    // lane offset is always forced aligned; misaligned ones are flagged
    always_comb begin
        w_off = 2'b00;
        unique case (w_width)
            MEM_B:   w_off = i_addr_lo;
            MEM_H:   w_off = {i_addr_lo[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    always_comb begin
        o_misalign = 1'b0;
        unique case (w_width)
            MEM_B:   o_misalign = 1'b0;
            MEM_H:   o_misalign = i_addr_lo[0];
            default: o_misalign = |i_addr_lo;
        endcase
    end
`else
    assign o_misalign = 1'b0;
`endif

    always_comb begin
        o_load_data = w_shift;
        unique case (w_width)
            MEM_B:
                o_load_data = {{24{w_sx & w_shift[7]}},
                               w_shift[7:0]};
            MEM_H:
                o_load_data = {{16{w_sx & w_shift[15]}},
                               w_shift[15:0]};
            default:
                o_load_data = w_shift;
        endcase
    end

    always_comb begin
        o_byte_en = 4'b1111;
        w_rep     = i_wr_data;
        unique case (w_width)
            MEM_B: begin
                o_byte_en = 4'b0001 << w_off;
                w_rep     = {4{i_wr_data[7:0]}};
            end
            MEM_H: begin
                o_byte_en = 4'b0011 << w_off;
                w_rep     = {2{i_wr_data[15:0]}};
            end
            default: begin
                o_byte_en = 4'b1111;
                w_rep     = i_wr_data;
            end
        endcase
    end

    always_comb begin
        o_store_word = i_ram_word;
        for (int b = 0; b < 4; b++) begin
            if (o_byte_en[b])
                o_store_word[8*b +: 8] = w_rep[8*b +: 8];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: MAR/MDR FSM, wait states and word RAM.
// Optional DATA_MEM_MISALIGN_CHECK_EN rejects unaligned accesses.
module data_mem_resp
    import data_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        mem_clk,
    input  logic        mem_rst,
    input  logic        mar_wr_en,
    input  logic [31:0] addr_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_wr_en,
    input  logic [31:0] wr_data_in,
    input  logic        mdr_rd_en,
    output logic [31:0] rd_data_out,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        misalign_err
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAST  = 4'(WAIT_STATES);

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_op_wr;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_rd_data;
    logic        r_busy;
    logic        r_ready;
    logic        r_err;

    logic [31:0] r_ram [DEPTH];

    logic                  w_latch;
    logic                  w_cmd_wr;
    logic                  w_cmd_rd;
    logic                  w_done;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_ram_word;
    logic [31:0]           w_load;
    logic [31:0]           w_store;
    logic [3:0]            w_be;
    logic                  w_mis;
    logic                  w_unused;

    assign w_idx      = r_addr[DEPTH_LOG2+1:2];
    assign w_ram_word = r_ram[w_idx];
    assign w_unused   = ^{r_addr[31:DEPTH_LOG2+2], w_be};

    mem_lane_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_ram_word   (w_ram_word),
        .i_wr_data    (r_wdata),
        .o_load_data  (w_load),
        .o_store_word (w_store),
        .o_byte_en    (w_be),
        .o_misalign   (w_mis)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cmd_wr    = 1'b0;
        w_cmd_rd    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (mar_wr_en) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // a command beats a simultaneous MAR write
                if (mem_wr_en) begin
                    w_cmd_wr    = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else if (mdr_rd_en) begin
                    w_cmd_rd    = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else if (mar_wr_en) begin
                    w_latch     = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (r_wait_cnt == LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_wdata    <= '0;
            r_op_wr    <= 1'b0;
            r_wait_cnt <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_ACCESS);
            r_ready <= w_done;
            r_err   <= w_done & w_mis;
            if (w_latch) begin
                r_addr   <= addr_in;
                r_funct3 <= funct3_in;
            end
            if (w_cmd_wr)
                r_wdata <= wr_data_in;
            if (w_cmd_wr | w_cmd_rd) begin
                r_op_wr    <= w_cmd_wr;
                r_wait_cnt <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (w_done & ~r_op_wr & ~w_mis)
                r_rd_data <= w_load;
        end
    end

    // RAM has no reset; a reset on the final edge suppresses the write
    always_ff @(posedge mem_clk) begin
        if (!mem_rst && w_done && r_op_wr && !w_mis)
            r_ram[w_idx] <= w_store;
    end

    assign rd_data_out  = r_rd_data;
    assign mem_busy     = r_busy;
    assign mem_ready    = r_ready;
    assign misalign_err = r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (WAIT_STATES 0 and 3).
// Timeline/memory model checked every cycle plus literal pins.
module tb_data_mem_resp;

    logic        clk;
    logic        rst   [2];
    logic        mar   [2];
    logic        wr    [2];
    logic        rd    [2];
    logic [31:0] addr  [2];
    logic [2:0]  f3s   [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        ready [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    int          ready_at [2];
    int          busy_lo  [2];
    int          busy_hi  [2];
    int          rst_at   [2];
    bit          exp_err  [2];
    logic [31:0] mdr_now  [2];
    logic [31:0] mdr_next [2];
    logic [31:0] mm [2][1024];

    data_mem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
        .mem_clk(clk), .mem_rst(rst[0]), .mar_wr_en(mar[0]),
        .addr_in(addr[0]), .funct3_in(f3s[0]), .mem_wr_en(wr[0]),
        .wr_data_in(wdata[0]), .mdr_rd_en(rd[0]),
        .rd_data_out(rdata[0]), .mem_busy(busy[0]),
        .mem_ready(ready[0]), .misalign_err(err[0])
    );

    data_mem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_dut1 (
        .mem_clk(clk), .mem_rst(rst[1]), .mar_wr_en(mar[1]),
        .addr_in(addr[1]), .funct3_in(f3s[1]), .mem_wr_en(wr[1]),
        .wr_data_in(wdata[1]), .mdr_rd_en(rd[1]),
        .rd_data_out(rdata[1]), .mem_busy(busy[1]),
        .mem_ready(ready[1]), .misalign_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h cycle %0d",
                     nm, got, exp, cyc);
        end
    endtask

    // what an access must do, from the byte-lane rules
    task automatic model_access(input int i, input bit is_wr,
                                input logic [31:0] a,
                                input logic [2:0] f3,
                                input logic [31:0] d);
        int w, sz, off;
        bit mis;
        logic [31:0] v;
        w   = int'(a[11:2]);
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        mis = (off % sz) != 0;
        exp_err[i]  = 1'b0;
        mdr_next[i] = mdr_now[i];
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        if (mis) begin
            exp_err[i] = 1'b1;
            return;
        end
`else
        if (mis) off = off - (off % sz);
`endif
        if (is_wr) begin
            for (int b = 0; b < sz; b++)
                mm[i][w][8*(off+b) +: 8] = d[8*b +: 8];
        end else begin
            v = mm[i][w] >> (8 * off);
            if (sz < 4) begin
                v = v & ((32'd1 << (8 * sz)) - 32'd1);
                if (!f3[2] && v[8*sz-1])
                    v = v | (32'hFFFF_FFFF << (8 * sz));
            end
            mdr_next[i] = v;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc == rst_at[i])   mdr_now[i] = 32'h0;
                if (cyc == ready_at[i]) mdr_now[i] = mdr_next[i];
                check($sformatf("ready%0d", i), 32'(ready[i]),
                      32'(cyc == ready_at[i]));
                check($sformatf("err%0d", i), 32'(err[i]),
                      32'(cyc == ready_at[i] && exp_err[i]));
                check($sformatf("busy%0d", i), 32'(busy[i]),
                      32'(cyc >= busy_lo[i] && cyc <= busy_hi[i]));
                check($sformatf("rdata%0d", i), rdata[i], mdr_now[i]);
            end
        end
    end

    task automatic clr(input int i);
        mar[i] = 0; wr[i] = 0; rd[i] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            clr(0); clr(1);
        end
    endtask

    // MAR cycle, command cycle, then the ACCESS cycles
    task automatic cmd(input int i, input bit is_wr,
                       input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] d, input bit junk);
        int c1;
        @(posedge clk); #1;
        mar[i] = 1; wr[i] = 0; rd[i] = 0;
        addr[i] = a; f3s[i] = f3;
        @(posedge clk); #1;
        mar[i] = 0; wr[i] = is_wr; rd[i] = !is_wr;
        wdata[i] = d; addr[i] = $urandom; f3s[i] = 3'($urandom);
        c1 = cyc;
        model_access(i, is_wr, a, f3, d);
        busy_lo[i]  = c1 + 1;
        busy_hi[i]  = c1 + 1 + ws(i);
        ready_at[i] = c1 + 2 + ws(i);
        for (int k = 0; k <= ws(i); k++) begin
            @(posedge clk); #1;
            if (junk) begin
                mar[i] = 1; wr[i] = 1; rd[i] = 1;
                addr[i] = $urandom; wdata[i] = $urandom;
            end else begin
                clr(i);
            end
        end
    endtask

    task automatic store(input int i, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] d);
        cmd(i, 1'b1, a, f3, d, i == 1);
    endtask

    task automatic load(input int i, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] lit,
                        input string nm);
        cmd(i, 1'b0, a, f3, 32'h0, i == 1);
        @(posedge clk); #1;
        clr(i);
        check(nm, rdata[i], lit);
        check({nm, "_rdy"}, 32'(ready[i]), 32'd1);
    endtask

    task automatic abort_store(input int i, input logic [31:0] a,
                               input logic [31:0] d);
        int c1;
        @(posedge clk); #1;
        mar[i] = 1; wr[i] = 0; rd[i] = 0;
        addr[i] = a; f3s[i] = 3'b010;
        @(posedge clk); #1;
        mar[i] = 0; wr[i] = 1; wdata[i] = d;
        c1 = cyc;
        busy_lo[i]  = c1 + 1;
        busy_hi[i]  = c1 + 1 + ws(i);
        ready_at[i] = -1;
        rst_at[i]   = c1 + 2 + ws(i);
        for (int k = 0; k <= ws(i); k++) begin
            @(posedge clk); #1;
            clr(i);
            if (k == ws(i)) rst[i] = 1;
        end
        @(posedge clk); #1;
        rst[i] = 0;
        wr[i] = 1; rd[i] = 1;
        check("abort_mdr", rdata[i], 32'h0);
        check("abort_busy", 32'(busy[i]), 32'd0);
        @(posedge clk); #1;
        clr(i);
        idle(3);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; clr(i);
            addr[i] = 0; f3s[i] = 0; wdata[i] = 0;
            ready_at[i] = -1; busy_lo[i] = 1; busy_hi[i] = 0;
            rst_at[i] = -1; exp_err[i] = 0;
            mdr_now[i] = 0; mdr_next[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 0; rst[1] = 0;
        chk_en = 1;
        for (int i = 0; i < 2; i++) begin
            check("rst_rdata", rdata[i], 32'h0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_ready", 32'(ready[i]), 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
        end

        // WAIT_STATES = 0
        store(0, 32'h10, 3'b010, 32'hDEAD_BEEF);
        load(0, 32'h10, 3'b010, 32'hDEAD_BEEF, "lw10");
        load(0, 32'h1010, 3'b010, 32'hDEAD_BEEF, "lw_wrap");
        store(0, 32'h20, 3'b010, 32'h80FF_7F01);
        load(0, 32'h21, 3'b000, 32'h0000_007F, "lb21");
        load(0, 32'h22, 3'b000, 32'hFFFF_FFFF, "lb22");
        load(0, 32'h23, 3'b100, 32'h0000_0080, "lbu23");
        load(0, 32'h22, 3'b001, 32'hFFFF_80FF, "lh22");
        load(0, 32'h22, 3'b101, 32'h0000_80FF, "lhu22");
        load(0, 32'h20, 3'b011, 32'h80FF_7F01, "lw_f3_011");
        load(0, 32'h20, 3'b111, 32'h80FF_7F01, "lw_f3_111");
        store(0, 32'h30, 3'b010, 32'h1122_3344);
        store(0, 32'h31, 3'b000, 32'h0000_00AA);
        load(0, 32'h30, 3'b010, 32'h1122_AA44, "sb31");
        store(0, 32'h32, 3'b001, 32'h0000_BEEF);
        load(0, 32'h30, 3'b010, 32'hBEEF_AA44, "sh32");
        store(0, 32'h40, 3'b010, 32'h0102_0304);
        store(0, 32'h42, 3'b010, 32'hCAFE_F00D);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        load(0, 32'h40, 3'b010, 32'h0102_0304, "sw42_mis");
        load(0, 32'h21, 3'b001, 32'h0102_0304, "lh21_mis");
`else
        load(0, 32'h40, 3'b010, 32'hCAFE_F00D, "sw42_align");
        load(0, 32'h21, 3'b001, 32'h0000_7F01, "lh21_align");
`endif
        store(0, 32'h50, 3'b010, 32'h5555_AAAA);
        idle(2);
        abort_store(0, 32'h50, 32'h1234_5678);
        load(0, 32'h50, 3'b010, 32'h5555_AAAA, "abort_ram");

        // WAIT_STATES = 3, strobes toggled during ACCESS
        store(1, 32'h10, 3'b010, 32'h0BAD_F00D);
        load(1, 32'h10, 3'b010, 32'h0BAD_F00D, "ws3_lw");
        store(1, 32'h12, 3'b001, 32'h0000_8001);
        load(1, 32'h12, 3'b001, 32'hFFFF_8001, "ws3_lh");
        load(1, 32'h13, 3'b100, 32'h0000_0080, "ws3_lbu");
        load(1, 32'h10, 3'b010, 32'h8001_F00D, "ws3_word");
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the multicycle RV32I core. It services the control unit's memory strobes (`mar_wr_en`, `mem_wr_en`, `mdr_rd_en`) against an internal word-organised RAM. It performs byte, half and word loads and stores, little-endian, with sign or zero extension. It has configurable wait states and signals completion with a one-cycle ready pulse, and sits between the datapath's ALU/rs2 outputs and the writeback mux input that carries load data.

## Interface
Reset is synchronous and active-high; there is one clock. Parameters:
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_STATES`, default 0: extra access cycles per command (0–15).

Ports:
- `mem_clk` in 1: sole clock, rising edge.
- `mem_rst` in 1: synchronous, active-high reset.
- `mar_wr_en` in 1: latch `addr_in` and `funct3_in` as the pending access.
- `addr_in` in 32: byte address (ALU result).
- `funct3_in` in 3: RV32I width field. Bits [1:0] are 00 = byte, 01 = half, 10 = word. Bit 2 = 1 means unsigned load.
- `mem_wr_en` in 1: store command for the latched address.
- `wr_data_in` in 32: store data (rs2), sampled with `mem_wr_en`.
- `mdr_rd_en` in 1: load command for the latched address.
- `rd_data_out` out 32: MDR. Holds the extended load result until the next load completes.
- `mem_busy` out 1: high while in ACCESS.
- `mem_ready` out 1: one-cycle pulse when a command completes.
- `misalign_err` out 1: one-cycle pulse alongside `mem_ready` for a rejected access.

## Operation
States are IDLE, ADDR and ACCESS.
- **IDLE:** on `mar_wr_en`, latch address and funct3, then go to ADDR. `mem_wr_en` and `mdr_rd_en` are ignored here.
- **ADDR:**
  - `mar_wr_en` re-latches the address and funct3; the block stays in ADDR.
  - `mem_wr_en` latches `wr_data_in`, sets op = write, clears the wait counter and goes to ACCESS.
  - `mdr_rd_en` sets op = read and goes to ACCESS.
  - If both commands are asserted, write wins. A command has priority over a simultaneous `mar_wr_en`.
- **ACCESS:** lasts WAIT_STATES+1 cycles, and all strobes are ignored. On the final edge the block performs the access, pulses `mem_ready` and returns to IDLE.
- **Word index:** `addr[DEPTH_LOG2+1:2]`. Upper bits are ignored, so addresses wrap modulo RAM size.
- **Loads:** select the lane using `addr[1:0]`. Byte/half results are sign-extended, or zero-extended when funct3[2] = 1. The result is written to `rd_data_out`.
- **Stores:** read-modify-write with byte enables. A byte store writes lane `addr[1:0]`, a half store writes lanes {addr[1],0}+1..0, and a word store writes all lanes. Untouched lanes are preserved.
- **Undefined width:** funct3[1:0] = 11 is treated as word.
- **Reset:**
  - Values: state IDLE, `rd_data_out` 0, `mem_busy` 0, `mem_ready` 0, `misalign_err` 0, latched address/funct3/data 0.
  - RAM contents are not reset.
  - Reset during ACCESS aborts the command: no RAM write, no MDR update, no `mem_ready`. Reset takes precedence even on the completing edge.

## Timing
- Command sampled at edge E0 (the block is in ADDR). ACCESS occupies cycles E0..E0+WAIT_STATES.
- Completion is at edge E1 = E0+WAIT_STATES+1. `mem_ready`, `misalign_err` and the updated `rd_data_out` are visible in the cycle after E1.
- With WAIT_STATES = 0, `mar_wr_en` at cycle 0 and a command at cycle 1 give `mem_ready` in cycle 3.
- A new `mar_wr_en` is accepted in the same cycle `mem_ready` is high (state IDLE).
- `mem_busy` is registered: it is high exactly for the cycles the state is ACCESS.
- All outputs are registered; no input reaches any output combinationally.

## Configuration
Macro: `DATA_MEM_MISALIGN_CHECK_EN`.
- **Defined:** a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 00, completes with normal timing but has no RAM write and no MDR change. `misalign_err` pulses together with `mem_ready`.
- **Undefined:** `misalign_err` is tied 0. Half accesses force addr[0] = 0 and word accesses force addr[1:0] = 00, so they proceed aligned.

## Structure
- **Shared package `data_mem_pkg`:**
  - state enum (IDLE/ADDR/ACCESS)
  - width constants (`MEM_B` = 2'b00, `MEM_H` = 2'b01, `MEM_W` = 2'b10)
  - funct3 unsigned bit index
- **Sub-module `mem_lane_align`:** combinational. It takes funct3, addr[1:0], the RAM word and the store data. It produces the extended load value, the merged store word, the 4-bit byte enable and the misalign flag.
- **Top level:** the FSM, wait counter, latches and RAM array.

## Test plan
- Word store 0xDEADBEEF at 0x10, then LW 0x10 → `rd_data_out` = 0xDEADBEEF, and `mem_ready` is a single pulse in cycle 3 after `mar_wr_en` (WAIT_STATES = 0).
- Word 0x80FF7F01 at 0x20:
  - LB 0x21 → 0x0000007F
  - LB 0x22 → 0xFFFFFFFF
  - LBU 0x23 → 0x00000080
  - LH 0x22 → 0xFFFF80FF
  - LHU 0x22 → 0x000080FF
- Preload 0x11223344 at 0x30:
  - SB 0xAA at 0x31 → word = 0x1122AA44
  - SH 0xBEEF at 0x32 → word = 0xBEEFAA44
- WAIT_STATES = 3: `mem_busy` is high for 4 cycles, `mem_ready` comes 5 cycles after the command, and strobes during ACCESS are ignored.
- Misalign with the macro defined: SW at 0x42 → `misalign_err` = 1, RAM unchanged. With the macro undefined: the store lands at 0x40 and `misalign_err` stays 0.
- Reset on the completing edge of a store to 0x50 → the RAM word is unchanged, `mem_ready` stays 0, and the state is IDLE.
